fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction encoding that halts fetch.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, the bubble encoding written into IF/ID.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port pc_init, input, 32 bits, boot PC value, sampled in BOOT.
REQ-006 The block SHALL have port stall, input, 1 bit, hazard stall: hold PC and IF/ID.
REQ-007 The block SHALL have port redirect, input, 1 bit, taken branch or jump resolved downstream.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits, redirect target.
REQ-009 The block SHALL have port imem_addr, output, 32 bits, instruction memory address, equal to program_counter.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits, instruction word, combinational read of imem_addr in the same cycle.
REQ-011 The block SHALL have port program_counter, output, 32 bits, current fetch PC.
REQ-012 The block SHALL have port if_id_instr, output, 32 bits, IF/ID latched instruction.
REQ-013 The block SHALL have port if_id_pc_plus4, output, 32 bits, IF/ID latched PC+4.
REQ-014 The block SHALL have port if_id_valid, output, 1 bit, IF/ID holds a real instruction.
REQ-015 The block SHALL have port halted, output, 1 bit, high while the FSM is in HALT.
REQ-016 The block SHALL have port fetch_count, output, 32 bits, count of instructions latched valid into IF/ID.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and HALT, with a 2-bit encoding.
REQ-018 In BOOT, the block SHALL load PC <= {pc_init[31:2],2'b00}, write NOP into IF/ID with valid 0, and move to RUN next cycle, ignoring stall and redirect.
REQ-019 In RUN, the per-cycle priority SHALL be redirect > stall > normal fetch.
REQ-020 Normal fetch in RUN SHALL perform: PC <= PC+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), if_id_instr <= imem_rdata, if_id_pc_plus4 <= PC+4, if_id_valid <= 1.
REQ-021 On stall without redirect, PC and all IF/ID outputs SHALL hold, and fetch_count SHALL not change.
REQ-022 On redirect, the block SHALL load PC <= {redirect_pc[31:2],2'b00}, write NOP_WORD into IF/ID with valid 0 (flush), and skip the fetched word, including when stall is also high.
REQ-023 In RUN, if a normal fetch latches imem_rdata == HALT_WORD, the FSM SHALL go to HALT; that word is latched with valid 1 and PC advances by 4.
REQ-024 In HALT, PC SHALL freeze; each cycle IF/ID SHALL be written NOP with valid 0, except under stall, where IF/ID holds.
REQ-025 A redirect in HALT SHALL load the target PC, flush IF/ID, and return the FSM to RUN.
REQ-026 fetch_count SHALL increment by 1 on each edge that writes if_id_valid=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-027 imem_addr and program_counter SHALL be combinational copies of the PC register.
REQ-028 halted SHALL be a registered-state decode, high exactly while the state is HALT.

Reset
REQ-029 When reset is sampled high, the block SHALL set state to BOOT, PC to 0, if_id_instr to NOP_WORD, if_id_pc_plus4 to 0, if_id_valid to 0, fetch_count to 0 and halted to 0.
REQ-030 Reset SHALL override stall and redirect, and asserting reset mid-run or in HALT SHALL discard all state.
REQ-031 The first edge with reset low SHALL execute BOOT, so PC = pc_init after that edge and the first valid IF/ID appears one edge later.

Verification
REQ-032 Boot: pc_init=1000, memory holds sequential non-halt words -> after release PC=1000, then 1004 with if_id_pc_plus4=1004 and valid=1, then 1008; fetch_count=3 after 3 fetches.
REQ-033 Stall: stall high for 2 cycles at PC=1008 -> PC stays 1008, IF/ID unchanged, fetch_count unchanged; fetch resumes at 1008 after stall drops.
REQ-034 Redirect with stall: redirect=1, redirect_pc=2003, stall=1 at the same edge -> PC=2000, if_id_valid=0, if_id_instr=NOP; next fetch gives if_id_pc_plus4=2004.
REQ-035 Halt: word at 1012 = 32'hFFFF_FFFF -> latched with valid=1, halted=1, PC frozen at 1016 with valid=0 thereafter; redirect to 1000 -> halted=0 and fetch resumes.
REQ-036 Wrap: redirect to 32'hFFFF_FFFC, then one fetch -> PC=0, if_id_pc_plus4=0.
REQ-037 Reset mid-run: reset pulsed while PC=1020 with fetch_count=5 -> all outputs at reset values, then BOOT reloads pc_init.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boot/run/halt FSM that drives the PC and the IF/ID latch.
// Priority in RUN and HALT is redirect > stall > normal fetch.
module fetch_stage #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_init,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] program_counter,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic [31:0] count_inc;

  assign pc_next4        = pc + 32'd4;
  assign count_inc       = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;
  assign imem_addr       = pc;
  assign program_counter = pc;
  assign halted          = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= '0;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc          <= {pc_init[31:2], 2'b00};
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            pc             <= pc_next4;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_next4;
            if_id_valid    <= 1'b1;
            fetch_count    <= count_inc;
            if (imem_rdata == HALT_WORD) state <= HALT;
          end
        end
        HALT: begin
          // PC stays frozen; only a redirect restarts fetch.
          if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            state       <= RUN;
          end else if (!stall) begin
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage, checked against a rule-level model.
module tb_fetch_stage;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_init = 32'd1000;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, program_counter;
  logic [31:0] if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] halt_addr = 32'd1012;
  logic [31:0] seed = 32'h5A5A_0001;

  int checks = 0;
  int errors = 0;

  // Memory image: one halt word at halt_addr, otherwise hashed non-halt words.
  function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] ha,
                                          input logic [31:0] s);
    logic [31:0] w;
    if (a == ha) return HALT_W;
    w = (a * 32'h9E37_79B1) ^ s;
    if (w == HALT_W) w = w ^ 32'h1;
    return w;
  endfunction

  assign imem_rdata = word_at(imem_addr, halt_addr, seed);

  fetch_stage #(.HALT_WORD(HALT_W), .NOP_WORD(NOP_W)) dut (
    .clk(clk), .reset(reset), .pc_init(pc_init), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .program_counter(program_counter), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted, m_boot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc", program_counter, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", if_id_instr, m_instr);
    chk("pc_plus4", if_id_pc_plus4, m_pc4);
    chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("count", fetch_count, m_count);
  endtask

  // Apply one cycle of inputs, advance the model by the stated rules, then compare.
  task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    logic [31:0] w;
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    if (rst) begin
      m_pc = 0; m_instr = NOP_W; m_pc4 = 0; m_valid = 0; m_count = 0;
      m_halted = 0; m_boot = 1;
    end else if (m_boot) begin
      m_pc = pc_init & ~32'd3; m_instr = NOP_W; m_valid = 0; m_boot = 0;
    end else if (rdr) begin
      m_pc = rpc & ~32'd3; m_instr = NOP_W; m_valid = 0; m_halted = 0;
    end else if (stl) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = NOP_W; m_valid = 0;
    end else begin
      w = word_at(m_pc, halt_addr, seed);
      m_instr = w; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (w == HALT_W) m_halted = 1;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  initial begin
    step(1, 1, 1, 32'd500);
    step(1, 0, 0, 0);
    chk("reset_pc", program_counter, 32'd0);
    chk("reset_count", fetch_count, 32'd0);

    // Boot and sequential fetch
    step(0, 1, 1, 32'd3000);            // BOOT ignores stall/redirect
    chk("boot_pc", program_counter, 32'd1000);
    step(0, 0, 0, 0);
    chk("fetch1_pc4", if_id_pc_plus4, 32'd1004);
    chk("fetch1_valid", {31'd0, if_id_valid}, 32'd1);
    step(0, 0, 0, 0);
    chk("fetch2_pc", program_counter, 32'd1008);

    // Stall two cycles at 1008
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_pc", program_counter, 32'd1008);
    chk("stall_count", fetch_count, 32'd2);
    step(0, 0, 0, 0);
    chk("resume_pc4", if_id_pc_plus4, 32'd1012);
    chk("count3", fetch_count, 32'd3);

    // Redirect with stall, unaligned target
    step(0, 1, 1, 32'd2003);
    chk("rdr_pc", program_counter, 32'd2000);
    chk("rdr_instr", if_id_instr, NOP_W);
    step(0, 0, 0, 0);
    chk("rdr_pc4", if_id_pc_plus4, 32'd2004);

    // Halt word at 1012
    step(0, 0, 1, 32'd1012);
    step(0, 0, 0, 0);
    chk("halt_instr", if_id_instr, HALT_W);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("halt_pc", program_counter, 32'd1016);
    chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 1, 32'd1000);
    chk("unhalt", {31'd0, halted}, 32'd0);
    step(0, 0, 0, 0);
    chk("unhalt_pc4", if_id_pc_plus4, 32'd1004);

    // Wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc", program_counter, 32'd0);
    chk("wrap_pc4", if_id_pc_plus4, 32'd0);

    // Reset mid-run around 1020, then reboot
    step(0, 0, 1, 32'd1016);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midrst_count", fetch_count, 32'd0);
    step(0, 0, 0, 0);
    chk("reboot_pc", program_counter, 32'd1000);

    // Randomized traffic around the halt word
    for (int i = 0; i < 400; i++) begin
      logic r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      d = ($urandom_range(0, 99) < 12);
      t = 32'd984 + 32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3));
      if (i % 97 == 50) pc_init = 32'd992 + 32'($urandom_range(0, 7));
      step(r, s, d, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
